// File: rtl/tri_bus_arbiter_if.sv
// Request/grant bundle between bus agents and the tristate arbiter.
// master: agent side (drives req); slave: arbiter side (drives the rest).
interface tri_bus_arbiter_if #(
  parameter int N = 4
);
  localparam int OW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  en;
  logic [OW-1:0] owner;
  logic          last;
  logic          busy;

  modport master (
    output req,
    input  gnt,
    input  en,
    input  owner,
    input  last,
    input  busy
  );

  modport slave (
    input  req,
    output gnt,
    output en,
    output owner,
    output last,
    output busy
  );
endinterface

// File: rtl/tri_bus_arbiter.sv
// Round-robin tristate bus arbiter with burst cap and turnaround gaps.
// Ports: clk, rst_n (async low), bus (slave: req in; gnt/en/owner/last/busy out).
module tri_bus_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8,
  parameter int TURN_CYC  = 1
) (
  input logic               clk,
  input logic               rst_n,
  tri_bus_arbiter_if.slave  bus
);
  localparam int OW = $clog2(N);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);
  localparam bit LAST1 = (MAX_BURST == 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    TURN
  } state_t;

  state_t        state;
  logic [N-1:0]  gnt_q;
  logic [N-1:0]  en_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic          last_q;
  logic          busy_q;
  logic [BW-1:0] bcnt;
  logic [TW-1:0] tcnt;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [OW-1:0]  off;
  logic [OW:0]    sum;
  logic           win_vld;
  logic [OW-1:0]  win_idx;
  logic [OW-1:0]  nxt_ptr;
  logic [N-1:0]   win_oh;
  logic           own_req;
  logic           cap_hit;
  logic           turn_end;

  // Rotate req so bit 0 is the priority pointer; the lowest
  // set bit of the rotated vector is the round-robin winner.
  always_comb begin
    dbl = {bus.req, bus.req} >> ptr_q;
    rot = dbl[N-1:0];
    win_vld = |rot;
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = OW'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (OW + 1)'(N)) begin
      sum = sum - (OW + 1)'(N);
    end
    win_idx = sum[OW-1:0];
  end

  always_comb begin
    nxt_ptr = win_idx + 1'b1;
    if (win_idx == OW'(N - 1)) nxt_ptr = '0;
    win_oh = N'(1) << win_idx;
  end

  assign own_req  = bus.req[owner_q];
  assign cap_hit  = (bcnt == BW'(MAX_BURST));
  assign turn_end = (tcnt == TW'(TURN_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_q   <= '0;
      en_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      bcnt    <= '0;
      tcnt    <= '0;
    end else begin
      unique case (state)
        IDLE, TURN: begin
          if (state == TURN && !turn_end) begin
            tcnt <= tcnt + 1'b1;
          end else if (win_vld) begin
            state   <= DRIVE;
            gnt_q   <= win_oh;
            en_q    <= win_oh;
            owner_q <= win_idx;
            ptr_q   <= nxt_ptr;
            bcnt    <= BW'(1);
            last_q  <= LAST1;
            busy_q  <= 1'b1;
            tcnt    <= '0;
          end else begin
            state  <= IDLE;
            busy_q <= 1'b0;
            bcnt   <= '0;
            tcnt   <= '0;
          end
        end
        DRIVE: begin
          // Release or cap both end the grant; no last
          // pulse is generated for a released grant.
          if (!own_req || cap_hit) begin
            state  <= TURN;
            gnt_q  <= '0;
            en_q   <= '0;
            last_q <= 1'b0;
            tcnt   <= TW'(1);
          end else begin
            bcnt   <= bcnt + 1'b1;
            last_q <= ((bcnt + 1'b1) == BW'(MAX_BURST));
          end
        end
        default: begin
          state  <= IDLE;
          gnt_q  <= '0;
          en_q   <= '0;
          last_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.en    = en_q;
  assign bus.owner = owner_q;
  assign bus.last  = last_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed + random bench for tri_bus_arbiter.
// Three instances cover default, short-burst and long-turnaround configs.
module tb_tri_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tri_bus_arbiter_if #(.N(4)) if_a ();
  tri_bus_arbiter_if #(.N(4)) if_b ();
  tri_bus_arbiter_if #(.N(4)) if_c ();

  tri_bus_arbiter #(.N(4), .MAX_BURST(8), .TURN_CYC(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  tri_bus_arbiter #(.N(4), .MAX_BURST(2), .TURN_CYC(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );
  tri_bus_arbiter #(.N(4), .MAX_BURST(3), .TURN_CYC(2)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  string       tag_q[$];

  function automatic logic [11:0] pk(
    input logic [3:0] g, input logic [3:0] e,
    input logic [1:0] o, input logic l, input logic b);
    return {g, e, o, l, b};
  endfunction

  function automatic logic [11:0] obs(input int d);
    if (d == 0)
      return pk(if_a.gnt, if_a.en, if_a.owner, if_a.last, if_a.busy);
    return pk(if_b.gnt, if_b.en, if_b.owner, if_b.last, if_b.busy);
  endfunction

  task automatic check(input string tag, input logic [11:0] o,
                       input logic [11:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h (gnt,en,own,last,busy) expected %h",
             tag, o, e);
    end
  endtask

  // Push expectation with stimulus, pop after the sampling edge.
  task automatic step(input int d, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] o,
                      input logic l, input logic b, input string tag);
    if (d == 0) if_a.req = r;
    else if_b.req = r;
    exp_q.push_back(pk(g, g, o, l, b));
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), obs(d), exp_q.pop_front());
  endtask

  initial begin
    logic [3:0] g;
    logic [3:0] cur;
    logic [3:0] prev_en;
    logic [3:0] last_nz;
    int zrun;
    if_a.req = '0;
    if_b.req = '0;
    if_c.req = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", obs(0), 12'h000);
    check("reset_b", obs(1), 12'h000);
    rst_n = 1'b1;

    // single requester, 3 cycles, released
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1, "single_d1");
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1, "single_d2");
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1, "single_d3");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1, "single_turn");
    step(0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "single_idle");

    // pointer is 3: req 0011 -> 0 then 1
    step(0, 4'b0011, 4'b0001, 2'd0, 1'b0, 1'b1, "wrap_g0");
    step(0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b1, "wrap_turn");
    step(0, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b1, "wrap_g1");

    // async reset in the middle of a grant
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", obs(0), 12'h000);
    if_a.req = '0;
    @(posedge clk);
    #1;
    check("rst_hold", obs(0), 12'h000);
    rst_n = 1'b1;
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b1, "rst_regrant");

    // burst cap: 8 drive cycles, last on 8th, 1 idle cycle
    for (int i = 2; i <= 8; i++)
      step(0, 4'b0001, 4'b0001, 2'd0, (i == 8), 1'b1, "burst1");
    step(0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1, "burst_turn1");
    for (int i = 1; i <= 8; i++)
      step(0, 4'b0001, 4'b0001, 2'd0, (i == 8), 1'b1, "burst2");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, "burst_turn2");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "burst_idle");

    // round robin, MAX_BURST=2: 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      g = 4'b0001 << (k % 4);
      step(1, 4'b1111, g, 2'(k % 4), 1'b0, 1'b1, "rr_first");
      step(1, 4'b1111, g, 2'(k % 4), 1'b1, 1'b1, "rr_last");
      if (k < 4)
        step(1, 4'b1111, 4'b0000, 2'(k % 4), 1'b0, 1'b1, "rr_turn");
    end
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1, "rr_end_turn");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");

    // random contention on TURN_CYC=2 instance
    prev_en = '0;
    last_nz = '0;
    zrun = 0;
    for (int c = 0; c < 10000; c++) begin
      if_c.req = 4'($urandom);
      @(posedge clk);
      #1;
      cur = if_c.en;
      check("onehot", 12'($countones(cur) <= 1), 12'd1);
      if (cur != 4'b0000) begin
        if (prev_en != 4'b0000)
          check("no_direct_swap", 12'(cur), 12'(prev_en));
        else if (last_nz != 4'b0000 && cur != last_nz)
          check("turn_gap", 12'(zrun >= 2), 12'd1);
        last_nz = cur;
        zrun = 0;
      end else begin
        zrun++;
      end
      prev_en = cur;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
